mc_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the MIPS datapath through fetch, decode, execute, memory and write-back.
- Replaces per-instruction single-cycle decode with a staged state machine.
- Instruction fetch and data access share one memory port; that port uses a req/ready handshake.
- Sits between the instruction register (opcode/funct) and the datapath muxes, PC, register file and ALU.

---
 rtl/mc_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB over one shared req/ready memory port.
// Define MC_ILLEGAL_TRAP_EN to trap illegal instructions in TRAP instead of skipping them as NOPs.
module mc_ctrl #(
   parameter int OP_W  = 6,
   parameter int ALU_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OP_W-1:0]  opcode,
   input  logic [OP_W-1:0]  func,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       data_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [ALU_W-1:0] alu_ctrl,
   output logic             ext_op,
   output logic [2:0]       state,
   output logic             illegal
);

   localparam logic [ALU_W-1:0] ALUOp_ADD  = ALU_W'(0);
   localparam logic [ALU_W-1:0] ALUOp_SUB  = ALU_W'(1);
   localparam logic [ALU_W-1:0] ALUOp_ADDU = ALU_W'(2);
   localparam logic [ALU_W-1:0] ALUOp_SUBU = ALU_W'(3);
   localparam logic [ALU_W-1:0] ALUOp_OR   = ALU_W'(4);
   localparam logic [ALU_W-1:0] ALUOp_LUI  = ALU_W'(5);
   localparam logic [ALU_W-1:0] ALUOp_SLT  = ALU_W'(6);

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
   localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
   localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);

   localparam logic [OP_W-1:0] FN_ADD  = OP_W'(6'b100000);
   localparam logic [OP_W-1:0] FN_ADDU = OP_W'(6'b100001);
   localparam logic [OP_W-1:0] FN_SUB  = OP_W'(6'b100010);
   localparam logic [OP_W-1:0] FN_SUBU = OP_W'(6'b100011);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_TRAP = 3'd5
   } state_t;

   state_t stateQ, stateD;

   logic isRtype, isAluR, isOri, isLui, isSlti, isLw, isSw, isBeq, isBne;
   logic isLegal;
   logic [ALU_W-1:0] rAluOp;

   assign isRtype = (opcode == OP_RTYPE);
   assign isAluR  = isRtype && ((func == FN_ADD) || (func == FN_ADDU) ||
                                (func == FN_SUB) || (func == FN_SUBU));
   assign isOri   = (opcode == OP_ORI);
   assign isLui   = (opcode == OP_LUI);
   assign isSlti  = (opcode == OP_SLTI);
   assign isLw    = (opcode == OP_LW);
   assign isSw    = (opcode == OP_SW);
   assign isBeq   = (opcode == OP_BEQ);
   assign isBne   = (opcode == OP_BNE);
   assign isLegal = isAluR || isOri || isLui || isSlti || isLw || isSw || isBeq || isBne;

   always_comb begin
      unique case (func)
         FN_SUB:  rAluOp = ALUOp_SUB;
         FN_ADDU: rAluOp = ALUOp_ADDU;
         FN_SUBU: rAluOp = ALUOp_SUBU;
         default: rAluOp = ALUOp_ADD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stateQ <= S_IF;
      else     stateQ <= stateD;
   end

   assign state = stateQ;

   always_comb begin
      stateD      = stateQ;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'b00;
      reg_write   = 1'b0;
      reg_dst     = 2'b00;
      data_to_reg = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_ctrl    = ALUOp_ADD;
      ext_op      = 1'b0;
      illegal     = 1'b0;

      unique case (stateQ)
         S_IF: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               stateD   = S_ID;
            end
         end
         // ALUOut captures PC+4 + (imm<<2) here so a branch can use it in EX.
         S_ID: begin
            alu_src_b = 2'b11;
            ext_op    = 1'b1;
            if (isLegal) begin
               stateD = S_EX;
            end else begin
`ifdef MC_ILLEGAL_TRAP_EN
               stateD = S_TRAP;
`else
               stateD = S_IF;
`endif
            end
         end
         S_EX: begin
            stateD = S_IF;
            if (isAluR) begin
               alu_src_a = 1'b1;
               alu_ctrl  = rAluOp;
               stateD    = S_WB;
            end else if (isOri || isLui) begin
               alu_src_b = 2'b10;
               alu_ctrl  = isOri ? ALUOp_OR : ALUOp_LUI;
               stateD    = S_WB;
            end else if (isSlti) begin
               alu_src_b = 2'b10;
               ext_op    = 1'b1;
               alu_ctrl  = ALUOp_SLT;
               stateD    = S_WB;
            end else if (isLw || isSw) begin
               alu_src_b = 2'b10;
               ext_op    = 1'b1;
               stateD    = S_MEM;
            end else if (isBeq || isBne) begin
               alu_src_a = 1'b1;
               alu_ctrl  = ALUOp_SUB;
               pc_src    = 2'b01;
               pc_write  = (isBeq & zero) | (isBne & ~zero);
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = isSw;
            if (mem_ready) stateD = isSw ? S_IF : S_WB;
         end
         S_WB: begin
            reg_write   = 1'b1;
            reg_dst     = isRtype ? 2'b01 : 2'b00;
            data_to_reg = isLw ? 2'b01 : 2'b00;
            stateD      = S_IF;
         end
         S_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
            illegal = 1'b1;
`else
            stateD  = S_IF;
`endif
         end
         default: stateD = S_IF;
      endcase

      // Reset kills any in-flight access immediately, so no write can complete.
      if (rst) begin
         mem_req     = 1'b0;
         mem_we      = 1'b0;
         iord        = 1'b0;
         ir_write    = 1'b0;
         pc_write    = 1'b0;
         pc_src      = 2'b00;
         reg_write   = 1'b0;
         reg_dst     = 2'b00;
         data_to_reg = 2'b00;
         alu_src_a   = 1'b0;
         alu_src_b   = 2'b00;
         alu_ctrl    = ALUOp_ADD;
         ext_op      = 1'b0;
         illegal     = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: walks each instruction class cycle by cycle
// and compares control outputs against hand-derived values.
module tb_mc_ctrl;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] func;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_we, iord, ir_write, pc_write;
   logic [1:0] pc_src;
   logic       reg_write;
   logic [1:0] reg_dst, data_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [4:0] alu_ctrl;
   logic       ext_op;
   logic [2:0] state;
   logic       illegal;

   int testsRun = 0;
   int testsFailed = 0;

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_OR  = 5'd4;

   mc_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg_write(reg_write), .reg_dst(reg_dst), .data_to_reg(data_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
      .ext_op(ext_op), .state(state), .illegal(illegal)
   );

   logic [24:0] allOut;
   assign allOut = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                    reg_dst, data_to_reg, alu_src_a, alu_src_b, alu_ctrl, ext_op,
                    state, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison funnels through here so the counters stay in one place.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [5:0] opc, input logic [5:0] fn,
                                input logic z, input logic rdy);
      opcode    = opc;
      func      = fn;
      zero      = z;
      mem_ready = rdy;
      #1;
      checkOutput("rw_vs_req", {31'd0, reg_write & mem_req}, 32'd0);
      checkOutput("we_outside_mem", {31'd0, mem_we & (state != 3'd3)}, 32'd0);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] addStates [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
   logic [2:0] lwStates  [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
   logic       lwReady   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [5:0] brOp      [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
   logic       brZero    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic       brTaken   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      rst = 1'b1;
      opcode = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      #2;
      checkOutput("reset_all_zero", {7'd0, allOut}, 32'd0);
      nextCycle();
      rst = 1'b0;
      #1;

      // sw, then reset while MEM is stalled
      applyStimulus(6'b101011, 6'd0, 1'b0, 1'b1);
      checkOutput("sw_if_state", {29'd0, state}, 32'd0);
      checkOutput("sw_if_ir_pc", {30'd0, ir_write, pc_write}, 32'd3);
      checkOutput("sw_if_alusrcb", {30'd0, alu_src_b}, 32'd1);
      nextCycle();
      applyStimulus(6'b101011, 6'd0, 1'b0, 1'b1);
      checkOutput("sw_id_state", {29'd0, state}, 32'd1);
      checkOutput("sw_id_srcb_ext", {29'd0, alu_src_b, ext_op}, 32'd7);
      nextCycle();
      applyStimulus(6'b101011, 6'd0, 1'b0, 1'b1);
      checkOutput("sw_ex_srcb", {30'd0, alu_src_b}, 32'd2);
      checkOutput("sw_ex_alu", {27'd0, alu_ctrl}, {27'd0, ALU_ADD});
      nextCycle();
      applyStimulus(6'b101011, 6'd0, 1'b0, 1'b0);
      checkOutput("sw_mem_req_we_iord", {29'd0, mem_req, mem_we, iord}, 32'd7);
      nextCycle();
      applyStimulus(6'b101011, 6'd0, 1'b0, 1'b0);
      checkOutput("sw_mem_held", {29'd0, state}, 32'd3);
      checkOutput("sw_mem_we_stable", {31'd0, mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_mem_outputs", {7'd0, allOut}, 32'd0);
      checkOutput("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
      nextCycle();
      rst = 1'b0;
      #1;
      checkOutput("post_rst_state", {29'd0, state}, 32'd0);
      checkOutput("post_rst_req", {31'd0, mem_req}, 32'd1);

      // add with zero-wait memory
      for (int i = 0; i < 4; i++) begin
         applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1);
         checkOutput("add_state", {29'd0, state}, {29'd0, addStates[i]});
         checkOutput("add_reg_write", {31'd0, reg_write}, {31'd0, (i == 3)});
         if (i == 2) checkOutput("add_ex_alu", {25'd0, alu_src_a, alu_src_b, alu_ctrl},
                                 {25'd0, 1'b1, 2'b00, ALU_ADD});
         if (i == 3) checkOutput("add_reg_dst", {30'd0, reg_dst}, 32'd1);
         nextCycle();
      end

      // lw with two wait cycles in MEM
      for (int i = 0; i < 7; i++) begin
         applyStimulus(6'b100011, 6'd0, 1'b0, lwReady[i]);
         checkOutput("lw_state", {29'd0, state}, {29'd0, lwStates[i]});
         checkOutput("lw_mem_we", {31'd0, mem_we}, 32'd0);
         if (i >= 3 && i <= 5) checkOutput("lw_mem_iord_req", {30'd0, iord, mem_req}, 32'd3);
         if (i == 6) checkOutput("lw_wb_dtr", {28'd0, data_to_reg, reg_dst}, 32'h4);
         nextCycle();
      end

      // beq/bne taken and not-taken
      for (int b = 0; b < 4; b++) begin
         applyStimulus(brOp[b], 6'd0, brZero[b], 1'b1);
         checkOutput("br_if_state", {29'd0, state}, 32'd0);
         nextCycle();
         applyStimulus(brOp[b], 6'd0, brZero[b], 1'b1);
         nextCycle();
         applyStimulus(brOp[b], 6'd0, brZero[b], 1'b1);
         checkOutput("br_ex_state", {29'd0, state}, 32'd2);
         checkOutput("br_pc_write", {31'd0, pc_write}, {31'd0, brTaken[b]});
         checkOutput("br_pc_src", {30'd0, pc_src}, 32'd1);
         checkOutput("br_alu", {27'd0, alu_ctrl}, {27'd0, ALU_SUB});
         nextCycle();
      end

      // IF stalled three cycles, then ori
      for (int i = 0; i < 3; i++) begin
         applyStimulus(6'b001101, 6'd0, 1'b0, 1'b0);
         checkOutput("if_stall_state", {29'd0, state}, 32'd0);
         checkOutput("if_stall_ir_pc", {30'd0, ir_write, pc_write}, 32'd0);
         nextCycle();
      end
      applyStimulus(6'b001101, 6'd0, 1'b0, 1'b1);
      checkOutput("if_ready_ir_pc", {30'd0, ir_write, pc_write}, 32'd3);
      nextCycle();
      applyStimulus(6'b001101, 6'd0, 1'b0, 1'b1);
      nextCycle();
      applyStimulus(6'b001101, 6'd0, 1'b0, 1'b1);
      checkOutput("ori_ex", {24'd0, alu_src_b, alu_ctrl, ext_op}, {24'd0, 2'b10, ALU_OR, 1'b0});
      nextCycle();
      applyStimulus(6'b001101, 6'd0, 1'b0, 1'b1);
      checkOutput("ori_wb", {27'd0, reg_write, reg_dst, data_to_reg}, 32'h10);
      nextCycle();

      // illegal opcode 111111
      applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
      checkOutput("ill_if_state", {29'd0, state}, 32'd0);
      nextCycle();
      applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
      checkOutput("ill_id_state", {29'd0, state}, 32'd1);
      checkOutput("ill_id_writes", {30'd0, reg_write, mem_we}, 32'd0);
      nextCycle();
`ifdef MC_ILLEGAL_TRAP_EN
      for (int i = 0; i < 2; i++) begin
         applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
         checkOutput("trap_outputs", {7'd0, allOut}, {7'd0, 25'b1011});
         nextCycle();
      end
`else
      applyStimulus(6'b111111, 6'd0, 1'b0, 1'b1);
      checkOutput("ill_nop_state", {29'd0, state}, 32'd0);
      checkOutput("ill_nop_flags", {29'd0, illegal, reg_write, mem_we}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
